// File: rtl/tile_row_fetch_arb_pkg.sv
// Shared tile geometry, colour/address types and sequencer state encoding
// for the tile-row fetch path between renderers and the sprite ROM.
package tile_pkg;

    localparam int TILE_W   = 20;
    localparam int TILE_H   = 20;
    localparam int TILE_PIX = 400;

    localparam logic [11:0] TRANSP_KEY = 12'h808;

    typedef logic [11:0] color_t;
    typedef logic [8:0]  rom_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    // row*20 + col without a multiplier; max result 399 fits in 9 bits
    function automatic rom_addr_t tile_addr(input logic [4:0] row, input logic [4:0] col);
        return (rom_addr_t'(row) << 4) + (rom_addr_t'(row) << 2) + rom_addr_t'(col);
    endfunction

endpackage

// File: rtl/tile_row_fetch_arb_rr_arbiter.sv
// Round-robin pick among N_REQ request levels, searching from last_id+1.
// Combinational; grant is one-hot only while update is high, grant_idx always reflects the pick.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_id,
    input  logic             update,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx
);

    logic [IDW:0] idx;
    logic         found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = {1'b0, last_id} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[IDW-1:0];
            end
        end
        if (update && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tile_row_fetch_arb.sv
// Arbitrates requesters onto one tile ROM and streams a 20-pixel row per grant.
// Latency: ack 1 cycle after req sampled in IDLE, pixels 2..21 cycles after; 21-cycle row period.
module tile_row_fetch_arb #(
    parameter int N_REQ  = 2,
    parameter int TILE_W = 20,
    parameter int TILE_H = 20,
    parameter int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*5-1:0] req_row,
    input  logic [N_REQ-1:0]   req_flip,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic [8:0]         rom_addr,
    input  logic [11:0]        rom_color,
    output logic               pix_valid,
    output logic [11:0]        pix_color,
    output logic               pix_transp,
    output logic               pix_last,
    output logic [IDW-1:0]     pix_id
);
    import tile_pkg::*;

    fetch_state_t     state_q, state_nxt;
    logic [4:0]       row_q, col_q, cnt_q;
    logic             flip_q;
    logic [IDW-1:0]   id_q, last_id_q;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             start, done;
    logic [4:0]       row_sel, row_clamped, col_start, col_step;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req       (req),
        .last_id   (last_id_q),
        .update    (state_q == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        row_sel     = req_row[5*int'(grant_idx) +: 5];
        row_clamped = (row_sel >= 5'(TILE_H)) ? 5'(TILE_H-1) : row_sel;
        col_start   = req_flip[grant_idx] ? 5'(TILE_W-1) : 5'd0;
        col_step    = flip_q ? (col_q - 5'd1) : (col_q + 5'd1);
    end

    always_comb begin
        state_nxt = state_q;
        start     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    start     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == 5'(TILE_W-1)) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Row sequencing: address is registered so it holds its last value in IDLE
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            flip_q    <= 1'b0;
            id_q      <= '0;
            last_id_q <= IDW'(N_REQ-1);
            rom_addr  <= '0;
            ack       <= '0;
            busy      <= 1'b0;
        end else begin
            ack <= grant;
            if (start) begin
                row_q     <= row_clamped;
                col_q     <= col_start;
                cnt_q     <= '0;
                flip_q    <= req_flip[grant_idx];
                id_q      <= grant_idx;
                last_id_q <= grant_idx;
                rom_addr  <= tile_addr(row_clamped, col_start);
                busy      <= 1'b1;
            end else if (state_q == FETCH) begin
                if (done) begin
                    busy <= 1'b0;
                end else begin
                    col_q    <= col_step;
                    cnt_q    <= cnt_q + 5'd1;
                    rom_addr <= tile_addr(row_q, col_step);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid  <= 1'b0;
            pix_color  <= '0;
            pix_transp <= 1'b0;
            pix_last   <= 1'b0;
            pix_id     <= '0;
        end else if (state_q == FETCH) begin
            pix_valid  <= 1'b1;
            pix_color  <= rom_color;
            pix_transp <= (rom_color == TRANSP_KEY);
            pix_last   <= done;
            pix_id     <= id_q;
        end else begin
            pix_valid  <= 1'b0;
            pix_transp <= 1'b0;
            pix_last   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tile_row_fetch_arb.sv
// Directed bench: per-cycle ack/busy/address checks in the stimulus thread,
// pixel stream checked by a queue-based monitor against a small ROM model.
module tb_tile_row_fetch_arb;

    logic        Clk;
    logic        Reset_n;
    logic [1:0]  req;
    logic [9:0]  req_row;
    logic [1:0]  req_flip;
    logic [1:0]  ack;
    logic        busy;
    logic [8:0]  rom_addr;
    logic [11:0] rom_color;
    logic        pix_valid;
    logic [11:0] pix_color;
    logic        pix_transp;
    logic        pix_last;
    logic [0:0]  pix_id;

    typedef struct packed {
        logic [11:0] color;
        logic        transp;
        logic        last;
        logic        id;
    } pix_t;

    pix_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   transp_seen = 0;

    tile_row_fetch_arb #(.N_REQ(2), .TILE_W(20), .TILE_H(20)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req        (req),
        .req_row    (req_row),
        .req_flip   (req_flip),
        .ack        (ack),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_color  (rom_color),
        .pix_valid  (pix_valid),
        .pix_color  (pix_color),
        .pix_transp (pix_transp),
        .pix_last   (pix_last),
        .pix_id     (pix_id)
    );

    // ROM model: address 65 holds the key colour, 66 a near-miss colour
    function automatic logic [11:0] rom_model(input int a);
        if (a == 65) return 12'h808;
        if (a == 66) return 12'hE50;
        return 12'(12'h100 + a);
    endfunction

    assign rom_color = rom_model(int'(rom_addr));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (pix_valid) begin
            if (pix_transp) transp_seen++;
            if (exp_q.size() == 0) begin
                chk("pixel_unexpected", {17'd0, pix_color, pix_transp, pix_last, pix_id}, 32'hFFFF_FFFF);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                chk("pixel", {17'd0, pix_color, pix_transp, pix_last, pix_id}, {17'd0, e});
            end
        end
    end

    function automatic int exp_addr(input int row_eff, input bit flip, input int i);
        return row_eff * 20 + (flip ? 19 - i : i);
    endfunction

    task automatic push_pixels(input int id, input int row_eff, input bit flip, input int n);
        for (int i = 0; i < n; i++) begin
            pix_t p;
            p.color  = rom_model(exp_addr(row_eff, flip, i));
            p.transp = (p.color == 12'h808);
            p.last   = (i == 19);
            p.id     = 1'(id);
            exp_q.push_back(p);
        end
    endtask

    // Caller has req presented in the current cycle (or it is held from a previous row)
    task automatic run_row(input int id, input int row_eff, input bit flip, input bit drop);
        push_pixels(id, row_eff, flip, 20);
        for (int c = 1; c <= 21; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (c == 1) begin
                chk("ack_grant", 32'(ack), 32'(1 << id));
                if (drop) req = 2'b00;
            end else begin
                chk("ack_quiet", 32'(ack), 32'd0);
            end
            if (c <= 20) begin
                chk("busy_fetch", 32'(busy), 32'd1);
                chk("rom_addr", 32'(rom_addr), 32'(exp_addr(row_eff, flip, c - 1)));
            end else begin
                chk("busy_idle", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"},  32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_pix"},  {17'd0, pix_valid, pix_color, pix_transp, pix_last}, 32'd0);
        chk({tag, "_id"},   32'(pix_id), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req      = 2'b00;
        req_row  = '0;
        req_flip = 2'b00;
        Reset_n  = 1'b1;
        #1 Reset_n = 1'b0;
        #2 chk_outputs_zero("reset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Held req=11 after reset: 0, then 1, then 0 every 21 cycles
        req_row = {5'd2, 5'd1};
        req     = 2'b11;
        run_row(0, 1, 1'b0, 1'b0);
        run_row(1, 2, 1'b0, 1'b0);
        run_row(0, 1, 1'b0, 1'b1);
        @(negedge Clk);
        chk("arb_idle_ack", 32'(ack), 32'd0);

        // Single row 3: addresses 60..79, key colour at 65 only
        transp_seen = 0;
        req_row  = {5'd0, 5'd3};
        req_flip = 2'b00;
        req      = 2'b01;
        run_row(0, 3, 1'b0, 1'b1);
        @(negedge Clk);
        chk("transp_count_fwd", 32'(transp_seen), 32'd1);

        // Mirrored row 3: addresses 79..60
        req_flip = 2'b01;
        req      = 2'b01;
        run_row(0, 3, 1'b1, 1'b1);
        @(negedge Clk);
        chk("transp_count_flip", 32'(transp_seen), 32'd2);

        // Row 25 clamps to 19: addresses 380..399, and mirrored 399..380 on requester 1
        req_flip = 2'b00;
        req_row  = {5'd0, 5'd25};
        req      = 2'b01;
        run_row(0, 19, 1'b0, 1'b1);
        req_row  = {5'd31, 5'd0};
        req_flip = 2'b10;
        req      = 2'b10;
        run_row(1, 19, 1'b1, 1'b1);
        @(negedge Clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during the 10th pixel of a row on requester 0
        req_flip = 2'b00;
        req_row  = {5'd0, 5'd5};
        req      = 2'b01;
        push_pixels(0, 5, 1'b0, 9);
        @(posedge Clk);
        @(negedge Clk);
        chk("midrow_ack", 32'(ack), 32'd1);
        req = 2'b00;
        repeat (10) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 chk_outputs_zero("midrow_reset");
        chk("midrow_consumed", 32'(exp_q.size()), 32'd0);
        repeat (2) begin
            @(negedge Clk);
            chk("reset_no_last", 32'(pix_last), 32'd0);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        chk_outputs_zero("post_reset");

        req_row  = {5'd2, 5'd0};
        req      = 2'b10;
        run_row(1, 2, 1'b0, 1'b1);
        @(negedge Clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_row_fetch_arb.md
# tile_row_fetch_arb

Sequencer and round-robin arbiter that shares one 20×20 tile sprite ROM (9-bit address, 12-bit combinational colour out) between several pixel requesters. Each grant streams one full tile row of 20 colours, in order or mirrored, with valid/last framing and a transparency flag. The block sits between the sprite/background renderers and the tile ROM instance in the VGA drawing path.

## Interface
- N_REQ, 2: number of requesters (2..4)
- TILE_W, 20: pixels per tile row
- TILE_H, 20: rows per tile

- Clk  in  1  system clock; all state on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level; held until its ack
- req_row  in  N_REQ×5  packed; requester i row in bits [5i+4:5i]
- req_flip  in  N_REQ  1 = stream the row right-to-left
- ack  out  N_REQ  one-hot, one-cycle pulse on grant
- busy  out  1  high while a row is being fetched
- rom_addr  out  9  address to the tile ROM
- rom_color  in  12  ROM colour for rom_addr, same cycle
- pix_valid  out  1  pix_* fields valid this cycle
- pix_color  out  12  registered ROM colour
- pix_transp  out  1  pix_color == TRANSP_KEY
- pix_last  out  1  final pixel of the row
- pix_id  out  $clog2(N_REQ)  requester that owns the pixel

## Operation
- States: IDLE, FETCH.
- IDLE: if any req bit is set, pick the winner round-robin, starting at (last_id+1) mod N_REQ. On that edge: register ack[winner]=1, busy=1, latch row/flip/id, and load col = flip ? TILE_W-1 : 0. Go to FETCH.
- Row clamp: a latched row >= TILE_H is replaced by TILE_H-1.
- FETCH:
  - rom_addr = row*TILE_W + col, computed as (row<<4)+(row<<2)+col, 9-bit result (max 399).
  - col steps +1, or -1 when flip, each cycle.
  - After the 20th address the state returns to IDLE and busy drops.
- Outputs: colour captured every FETCH cycle into pix_color, with pix_valid, pix_id and pix_transp one cycle later. pix_last marks the 20th pixel.
- Requester protocol: the requester may drop req after ack. A req still high after ack is a new request.
- req changes in FETCH are ignored until IDLE.
- rom_addr holds its last value in IDLE.
- Reset (any time, including mid-row):
  - state IDLE, all outputs 0, rom_addr 0.
  - last_id = N_REQ-1, so requester 0 has first priority.
  - A partial row is abandoned with no pix_last.

## Timing
- Req seen in IDLE at cycle T:
  - ack=1 at T+1, first rom_addr at T+1.
  - first pix_valid at T+2, pix_last at T+21.
  - busy covers T+1..T+20.
- IDLE at T+21 arbitrates again, so the next ack is at T+22. Fetch period is 21 cycles per row.
- pix_valid is continuous for 20 cycles with no bubbles.
- ack is never asserted in the same cycle as rom_addr of a previous row.

## Structure
- Package tile_pkg holds:
  - TILE_W, TILE_H, TILE_PIX=400
  - TRANSP_KEY=12'h808
  - color_t (logic [11:0]) and rom_addr_t (logic [8:0])
  - the state enum typedef
- One sub-module, rr_arbiter: parameterised N_REQ, with req vector, last_id and update strobe in, and one-hot grant plus grant index out.

## Test plan
- Single request: req[0]=1, row 3, no flip at T. Expect ack[0] at T+1, rom_addr 60,61..79 on T+1..T+20, pix_last at T+21, pix_id=0.
- Flip: row 3 with flip=1. Expect rom_addr 79 down to 60; pixel order mirrors the ROM contents.
- Clamp and boundary: row 25. Expect addresses 380..399; rom_addr never exceeds 399.
- Arbitration: after reset, req=2'b11 held. Expect ack[0] at T+1, ack[1] at T+22, ack[0] at T+43 (alternating), with no pixel overlap.
- Reset mid-row: assert Reset_n=0 at the 10th pixel. Expect all outputs 0 immediately and no pix_last. After release, req[1] alone is granted, with ack 1 cycle after it is sampled.
- Transparency: ROM returns 12'h808 on one address. Expect pix_transp=1 for exactly that pixel and 0 for 12'hE50.
